alu_seq: RTL and testbench

//  Parametrised, registered successor to the lab2 combinational ALU (ADD/SUB/NEG/PASS, Z/N).

---
 rtl/alu_seq.sv | 133 +++++++++++++
 tb/tb_alu_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a multi-cycle unsigned multiply.
// One operation in flight; the result is held in DONE until the consumer takes it.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_nxt;
    logic [WIDTH:0]       psum;
    logic [WIDTH:0]       addw;
    logic [WIDTH:0]       subw;
    logic [WIDTH-1:0]     res;
    logic                 rc;
    logic                 rv;
    logic                 accept;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);

    assign addw = {1'b0, A} + {1'b0, B};
    assign subw = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle result and carry/overflow for the non-multiply ops
    always_comb begin
        res = '0;
        rc  = 1'b0;
        rv  = 1'b0;
        unique case (op)
            3'b000: begin
                res = addw[WIDTH-1:0];
                rc  = addw[WIDTH];
                rv  = (A[WIDTH-1] == B[WIDTH-1]) & (res[WIDTH-1] != A[WIDTH-1]);
            end
            3'b001: begin
                res = subw[WIDTH-1:0];
                rc  = subw[WIDTH];
                rv  = (A[WIDTH-1] != B[WIDTH-1]) & (res[WIDTH-1] != A[WIDTH-1]);
            end
            3'b010: begin
                res = '0 - A;
                rv  = (A == MSB);
            end
            3'b011: res = A;
            default: res = '0;
        endcase
    end

    // One shift-add step: add multiplicand into the upper half if the
    // current multiplier bit is set, then shift the whole product right.
    assign psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                      (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign prod_nxt = {psum, prod[WIDTH-1:1]};

    // Handshake FSM, multiply datapath and registered result/flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            out   <= '0;
            Z     <= 1'b0;
            N     <= 1'b0;
            C     <= 1'b0;
            V     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (op == 3'b100) begin
                            state <= BUSY;
                            cnt   <= '0;
                            mcand <= A;
                            prod  <= {{WIDTH{1'b0}}, B};
                        end else begin
                            state <= DONE;
                            out   <= res;
                            Z     <= (res == '0);
                            N     <= res[WIDTH-1];
                            C     <= rc;
                            V     <= rv;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        out   <= prod_nxt[WIDTH-1:0];
                        Z     <= (prod_nxt[WIDTH-1:0] == '0);
                        N     <= prod_nxt[WIDTH-1];
                        C     <= 1'b0;
                        V     <= |prod_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus randomized ops checked
// against an arithmetic reference model, including latency and handshakes.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         Z;
    logic         N;
    logic         C;
    logic         V;

    int vectors = 0;
    int errors  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .Z        (Z),
        .N        (N),
        .C        (C),
        .V        (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: results derived from plain integer arithmetic
    task automatic ref_alu(input logic [2:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, output logic [W-1:0] r,
                           output logic [3:0] f);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        longint          sa;
        longint          sb;
        longint          s;
        logic            c;
        logic            v;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (o)
            3'd0: begin
                up = ua + ub;
                r  = up[W-1:0];
                c  = (up >= 64'h1_0000_0000);
                s  = sa + sb;
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                up = ua - ub;
                r  = up[W-1:0];
                c  = (ua >= ub);
                s  = sa - sb;
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: begin
                up = 64'd0 - ua;
                r  = up[W-1:0];
                s  = -sa;
                v  = (s > 64'sd2147483647);
            end
            3'd3: r = a;
            3'd4: begin
                up = ua * ub;
                r  = up[W-1:0];
                v  = (up >> 32) != 0;
            end
            default: r = '0;
        endcase
        f = {(r == 0), r[W-1], c, v};
    endtask

    // Issue one op from IDLE, measure latency, hold, then retire it
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic [3:0]   ef;
        int           lat;
        ref_alu(o, a, b, er, ef);
        op        = o;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom_range(0, 7));
        A        = $urandom;
        B        = $urandom;
        if (o == 3'd4) check("in_ready_busy", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, (o == 3'd4) ? 33 : 1);
        check("out", out, er);
        check("flags", {Z, N, C, V}, ef);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check("hold_out", out, er);
            check("hold_flags", {Z, N, C, V}, ef);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("retire_valid", out_valid, 0);
        check("idle_keeps_out", out, er);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] c[5];
        c = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        case ($urandom_range(0, 3))
            0: return W'($urandom_range(0, 15));
            1: return c[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out", out, 0);
        check("rst_flags", {Z, N, C, V}, 0);
        rst_n = 1'b1;

        run_op(3'd0, 32'd4, 32'd3, 0);
        run_op(3'd1, 32'd2, 32'd3, 0);
        run_op(3'd1, 32'd5, 32'd5, 0);
        run_op(3'd0, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(3'd2, 32'h8000_0000, 32'd0, 0);
        run_op(3'd2, 32'd5, 32'd0, 0);
        run_op(3'd2, 32'd0, 32'd0, 0);
        run_op(3'd3, 32'd5, 32'd9, 0);
        run_op(3'd4, 32'd6, 32'd7, 0);
        run_op(3'd4, 32'h1_0000, 32'h1_0000, 0);
        run_op(3'd6, 32'd12, 32'd34, 0);

        // Held result, then back-to-back accept while retiring
        run_op(3'd0, 32'd10, 32'd20, 0);
        op        = 3'd0;
        A         = 32'd10;
        B         = 32'd20;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("b2b_held_out", out, 30);
        check("b2b_held_in_ready", in_ready, 0);
        op        = 3'd0;
        A         = 32'd1;
        B         = 32'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_out", out, 2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_retire", out_valid, 0);

        // Reset in the middle of a multiply drops it
        op       = 3'd4;
        A        = 32'd123;
        B        = 32'd456;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midmul_rst_valid", out_valid, 0);
        check("midmul_rst_in_ready", in_ready, 1);
        check("midmul_rst_flags", {Z, N, C, V}, 0);
        check("midmul_rst_out", out, 0);
        run_op(3'd0, 32'd4, 32'd3, 0);

        for (int i = 0; i < 300; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(),
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
